sys_mem_arbiter: RTL and testbench

- Shares the single-port activation/weight memory between two requesters: port 0 = systolic controller (compute), port 1 = host loader/readback.
- Sits between both requesters and the memory macro, and replaces the direct controller-to-memory connection.
- Arbitration is round-robin with an optional bounded burst lock. Read returns are tagged with the requester that issued them.

---
 rtl/sys_mem_arbiter_pkg.sv | 16 +
 rtl/sys_mem_rd_tag_pipe.sv | 31 +++
 rtl/sys_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_sys_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_mem_arbiter_pkg.sv
// Shared types for the activation/weight memory arbiter: owner encoding and default address width.
package sys_mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } arb_owner_t;

  function automatic arb_owner_t port_owner(input logic port);
    return port ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/sys_mem_rd_tag_pipe.sv
// READ_LAT-deep valid + port-id shift register; the last stage qualifies mem_q for the issuing port.
module sys_mem_rd_tag_pipe #(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_port,
  output logic o_rvalid0,
  output logic o_rvalid1,
  output logic o_busy
);

  logic [READ_LAT-1:0] r_vld;
  logic [READ_LAT-1:0] r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld <= (r_vld << 1) | READ_LAT'(i_push);
      r_tag <= (r_tag << 1) | READ_LAT'(i_port);
    end
  end

  assign o_rvalid0 = r_vld[READ_LAT-1] & ~r_tag[READ_LAT-1];
  assign o_rvalid1 = r_vld[READ_LAT-1] &  r_tag[READ_LAT-1];
  assign o_busy    = |r_vld;

endmodule

// File: rtl/sys_mem_arbiter.sv
// Round-robin arbiter with bounded burst lock for the single-port activation/weight memory.
// Optional 32-bit grant/stall counters are built when SYS_MEM_ARB_STATS_EN is defined.
module sys_mem_arbiter
  import sys_mem_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_q,
  output logic              busy,
  output arb_owner_t        dbg_owner,
  output logic [7:0]        dbg_burst_cnt
`ifdef SYS_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1
`endif
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  // Handshake: a requester holds req/we/addr/wdata until gnt; req&gnt in a cycle is the accepted access.
  arb_owner_t r_owner;
  logic       r_last;
  logic [7:0] r_burst_cnt;

  logic w_own_port, w_own_req, w_own_lock, w_oth_req;
  logic w_hold, w_force, w_gnt0, w_gnt1, w_any_gnt, w_sel_lock;
  logic w_pipe_busy;

  always_comb begin
    w_own_port = (r_owner == OWN_P1);
    w_own_req  = w_own_port ? req1  : req0;
    w_own_lock = w_own_port ? lock1 : lock0;
    w_oth_req  = w_own_port ? req0  : req1;
    w_hold     = (r_owner != OWN_NONE) && w_own_req && w_own_lock;
    w_force    = w_hold && (r_burst_cnt == BURST_MAX) && w_oth_req;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    if (rst) begin
      if (w_hold) begin
        // A forced hand-over flips the grant to the waiting port.
        if (w_own_port ^ w_force) w_gnt1 = 1'b1;
        else                      w_gnt0 = 1'b1;
      end else if (req0 && req1) begin
        if (r_last) w_gnt0 = 1'b1;
        else        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_sel_lock = w_gnt1 ? lock1 : lock0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_NONE;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      if (w_any_gnt) r_last <= w_gnt1;
      if (w_force) begin
        r_owner     <= port_owner(w_gnt1);
        r_burst_cnt <= '0;
      end else if (w_hold) begin
        if (r_burst_cnt != BURST_MAX) r_burst_cnt <= r_burst_cnt + 8'd1;
      end else if (w_any_gnt && w_sel_lock) begin
        r_owner     <= port_owner(w_gnt1);
        r_burst_cnt <= 8'd1;
      end else begin
        r_owner     <= OWN_NONE;
        r_burst_cnt <= '0;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_addr  = addr0;
      mem_wren  = we0;
      mem_wdata = wdata0;
    end else if (w_gnt1) begin
      mem_addr  = addr1;
      mem_wren  = we1;
      mem_wdata = wdata1;
    end
  end

  sys_mem_rd_tag_pipe #(.READ_LAT(READ_LAT)) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .i_push    (w_any_gnt & ~mem_wren),
    .i_port    (w_gnt1),
    .o_rvalid0 (rvalid0),
    .o_rvalid1 (rvalid1),
    .o_busy    (w_pipe_busy)
  );

  assign gnt0          = w_gnt0;
  assign gnt1          = w_gnt1;
  assign rdata         = mem_q;
  assign busy          = w_pipe_busy | w_any_gnt;
  assign dbg_owner     = r_owner;
  assign dbg_burst_cnt = r_burst_cnt;

`ifdef SYS_MEM_ARB_STATS_EN
  logic [31:0] r_grant_cnt0, r_grant_cnt1, r_stall_cnt0, r_stall_cnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_stall_cnt0 <= '0;
      r_stall_cnt1 <= '0;
    end else begin
      if (w_gnt0 && r_grant_cnt0 != '1)           r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (w_gnt1 && r_grant_cnt1 != '1)           r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      if (req0 && !w_gnt0 && r_stall_cnt0 != '1) r_stall_cnt0 <= r_stall_cnt0 + 32'd1;
      if (req1 && !w_gnt1 && r_stall_cnt1 != '1) r_stall_cnt1 <= r_stall_cnt1 + 32'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign stall_cnt0 = r_stall_cnt0;
  assign stall_cnt1 = r_stall_cnt1;
`endif

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Bench for sys_mem_arbiter: directed scenarios plus random traffic against a behavioural arbiter/memory model.
module tb_sys_mem_arbiter;
  import sys_mem_arbiter_pkg::*;

  localparam int WIDTH     = 16;
  localparam int ADDR_W    = 12;
  localparam int READ_LAT  = 1;
  localparam int MAX_BURST = 4;

  typedef struct {
    int               port;
    int               due;
    logic [WIDTH-1:0] data;
  } rd_t;

  logic              clk, rst;
  logic              req0, req1, lock0, lock1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [WIDTH-1:0]  wdata0, wdata1, rdata, mem_wdata, mem_q;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy;
  arb_owner_t        dbg_owner;
  logic [7:0]        dbg_burst_cnt;
`ifdef SYS_MEM_ARB_STATS_EN
  logic [31:0]       grant_cnt0, grant_cnt1, stall_cnt0, stall_cnt1;
`endif

  sys_mem_arbiter #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q),
    .busy(busy), .dbg_owner(dbg_owner), .dbg_burst_cnt(dbg_burst_cnt)
`ifdef SYS_MEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  // ---------------- clock / reset / memory macro ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             mem_clear;
  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] q_pipe [READ_LAT];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
    end else if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
    end
    q_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < READ_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[READ_LAT-1];

  // ---------------- bench state ----------------
  int               n_checks, n_errors, now, last_win;
  bit               p_req [2];
  bit               p_lock[2];
  bit               p_we  [2];
  logic [ADDR_W-1:0] p_addr [2];
  logic [WIDTH-1:0]  p_wdata[2];
  int               mode [2];
  int               m_holder, m_run, m_last;
  int               g_cnt[2];
  int               s_cnt[2];
  logic [WIDTH-1:0] ref_mem [0:(1<<ADDR_W)-1];
  rd_t              exp_q[$];
  logic [1:0]       obs_gnt;
  logic             obs_rv0, obs_rv1;
  logic [WIDTH-1:0] obs_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    req0 = p_req[0];  req1 = p_req[1];
    lock0 = p_lock[0]; lock1 = p_lock[1];
    we0 = p_we[0];    we1 = p_we[1];
    addr0 = p_addr[0]; addr1 = p_addr[1];
    wdata0 = p_wdata[0]; wdata1 = p_wdata[1];
  endtask

  task automatic set_txn(input int p, input bit we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic new_txn(input int p);
    set_txn(p, ($urandom_range(0, 2) == 0), ADDR_W'($urandom_range(0, 63)), WIDTH'($urandom));
  endtask

  task automatic model_reset();
    m_holder = -1; m_run = 0; m_last = 1;
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin g_cnt[p] = 0; s_cnt[p] = 0; end
  endtask

  // One clock cycle: drive, check against the model at the falling edge, advance, reload requesters.
  task automatic step();
    int               win;
    bit               forced;
    bit               ev[2];
    bit               ebusy;
    logic [WIDTH-1:0] edata;
    logic [1:0]       egnt;
    arb_owner_t       eown;
    int               erun;
    rd_t              rd;
    drive();
    @(negedge clk);
    ev[0] = 1'b0; ev[1] = 1'b0; edata = '0;
    ebusy = (exp_q.size() != 0);
    if (exp_q.size() != 0 && exp_q[0].due == now) begin
      ev[exp_q[0].port] = 1'b1;
      edata = exp_q[0].data;
      exp_q.delete(0);
    end
    eown = (m_holder < 0) ? OWN_NONE : ((m_holder == 0) ? OWN_P0 : OWN_P1);
    erun = m_run;
    win = -1; forced = 1'b0;
    if (m_holder >= 0 && p_req[m_holder] && p_lock[m_holder]) begin
      if (m_run >= MAX_BURST && p_req[1-m_holder]) begin
        win = 1 - m_holder; forced = 1'b1;
      end else begin
        win = m_holder;
      end
    end else begin
      m_holder = -1;
      if (p_req[0] && p_req[1]) win = 1 - m_last;
      else if (p_req[0])        win = 0;
      else if (p_req[1])        win = 1;
    end
    egnt = (win == 0) ? 2'b01 : ((win == 1) ? 2'b10 : 2'b00);
    if (win >= 0) ebusy = 1'b1;
    obs_gnt = {gnt1, gnt0}; obs_rv0 = rvalid0; obs_rv1 = rvalid1; obs_rdata = rdata;
    check("gnt", 32'({gnt1, gnt0}), 32'(egnt));
    check("mem_wren", 32'(mem_wren), (win >= 0) ? 32'(p_we[win]) : 32'd0);
    check("mem_addr", 32'(mem_addr), (win >= 0) ? 32'(p_addr[win]) : 32'd0);
    check("mem_wdata", 32'(mem_wdata), (win >= 0) ? 32'(p_wdata[win]) : 32'd0);
    check("rvalid0", 32'(rvalid0), 32'(ev[0]));
    check("rvalid1", 32'(rvalid1), 32'(ev[1]));
    if (ev[0] || ev[1]) check("rdata", 32'(rdata), 32'(edata));
    check("busy", 32'(busy), 32'(ebusy));
    check("owner", 32'(dbg_owner), 32'(eown));
    check("burst_cnt", 32'(dbg_burst_cnt), 32'(erun));
    for (int p = 0; p < 2; p++) if (p_req[p] && win != p) s_cnt[p]++;
    if (win >= 0) begin
      g_cnt[win]++;
      if (p_we[win]) begin
        ref_mem[p_addr[win]] = p_wdata[win];
      end else begin
        rd.port = win; rd.due = now + READ_LAT; rd.data = ref_mem[p_addr[win]];
        exp_q.push_back(rd);
      end
      m_last = win;
      if (forced) begin
        m_holder = win; m_run = 0;
      end else if (win == m_holder) begin
        if (m_run < MAX_BURST) m_run++;
      end else begin
        m_holder = p_lock[win] ? win : -1;
        m_run    = p_lock[win] ? 1 : 0;
      end
    end else begin
      m_run = 0;
    end
    last_win = win;
    now++;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (last_win == p) begin
        case (mode[p])
          1:       begin new_txn(p); p_we[p] = 1'b0; end
          2:       if ($urandom_range(0, 3) != 0) new_txn(p); else p_req[p] = 1'b0;
          default: p_req[p] = 1'b0;
        endcase
        if (mode[p] == 2 && $urandom_range(0, 5) == 0) p_lock[p] = !p_lock[p];
      end else if (!p_req[p] && mode[p] == 2 && $urandom_range(0, 1) == 0) begin
        new_txn(p);
      end
    end
  endtask

  // Called at posedge+1; holds reset two cycles with both requests raised, then releases with ports idle.
  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1; we1 = 1'b1; addr0 = 12'h123; addr1 = 12'h321;
    wdata1 = 16'hA5A5;
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
      check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_bus", 32'({mem_wren, mem_addr, mem_wdata}), 32'd0);
      check("rst_owner", 32'(dbg_owner), 32'(OWN_NONE));
      @(posedge clk);
      #1;
    end
    for (int p = 0; p < 2; p++) begin p_req[p] = 1'b0; p_lock[p] = 1'b0; mode[p] = 0; end
    drive();
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n0, n1;
    n_checks = 0; n_errors = 0; now = 0; last_win = -1;
    rst = 1'b0; mem_clear = 1'b1;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_lock[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; mode[p] = 0;
    end
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = '0;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    do_reset();

    // Preload via port 1, then simultaneous reads after a fresh reset.
    set_txn(1, 1'b1, 12'h010, 16'd5);      step();
    set_txn(1, 1'b1, 12'h020, 16'hFFFD);   step();
    step();
    do_reset();
    set_txn(0, 1'b0, 12'h010, '0);
    set_txn(1, 1'b0, 12'h020, '0);
    step(); check("t1_first_gnt", 32'(obs_gnt), 32'd1);
    step(); check("t1_second_gnt", 32'(obs_gnt), 32'd2);
    check("t1_rvalid0", 32'(obs_rv0), 32'd1); check("t1_rdata0", 32'(obs_rdata), 32'h0005);
    step(); check("t1_rvalid1", 32'(obs_rv1), 32'd1); check("t1_rdata1", 32'(obs_rdata), 32'hFFFD);

    // Locked burst on port 0 with port 1 waiting.
    do_reset();
    mode[0] = 1; mode[1] = 1; p_lock[0] = 1'b1;
    set_txn(0, 1'b0, 12'h001, '0);
    set_txn(1, 1'b0, 12'h002, '0);
    for (int i = 0; i < MAX_BURST; i++) begin step(); check("t2_burst_gnt0", 32'(obs_gnt), 32'd1); end
    step(); check("t2_switch_gnt1", 32'(obs_gnt), 32'd2);
`ifdef SYS_MEM_ARB_STATS_EN
    check("t2_stall_cnt1", stall_cnt1, 32'd4);
`endif
    step(); check("t2_resume_gnt0", 32'(obs_gnt), 32'd1);
    mode[0] = 0; mode[1] = 0; p_req[0] = 1'b0; p_req[1] = 1'b0; p_lock[0] = 1'b0;
    repeat (3) step();

    // Write then read-after-write across ports.
    set_txn(1, 1'b1, 12'h100, 16'h7FFF); step(); check("t3_write_gnt", 32'(obs_gnt), 32'd2);
    set_txn(0, 1'b0, 12'h100, '0);       step(); check("t3_read_gnt", 32'(obs_gnt), 32'd1);
    step(); check("t3_rvalid0", 32'(obs_rv0), 32'd1); check("t3_rdata", 32'(obs_rdata), 32'h7FFF);

    // Reset while a port 1 read is in flight.
    set_txn(1, 1'b0, 12'h020, '0); step(); check("t4_accept", 32'(obs_gnt), 32'd2);
    do_reset();
    repeat (3) begin step(); check("t4_no_rvalid1", 32'(obs_rv1), 32'd0); end

    // Long single-requester lock: burst counter must saturate.
    mode[0] = 1; p_lock[0] = 1'b1; set_txn(0, 1'b0, 12'h005, '0);
    n0 = 0; n1 = 0;
    repeat (300) begin
      step();
      if (obs_gnt[0]) n0++;
      if (obs_gnt[1]) n1++;
    end
    check("t5_gnt0_count", 32'(n0), 32'd300);
    check("t5_gnt1_count", 32'(n1), 32'd0);
    check("t5_burst_sat", 32'(dbg_burst_cnt), 32'(MAX_BURST));
    mode[0] = 0; p_req[0] = 1'b0; p_lock[0] = 1'b0;
    repeat (3) step();

    // Random mixed traffic.
    mode[0] = 2; mode[1] = 2;
    repeat (3000) step();
    mode[0] = 0; mode[1] = 0; p_lock[0] = 1'b0; p_lock[1] = 1'b0;
    repeat (12) step();
    check("drain_idle", 32'({p_req[1], p_req[0]}), 32'd0);
`ifdef SYS_MEM_ARB_STATS_EN
    check("grant_cnt0", grant_cnt0, 32'(g_cnt[0]));
    check("grant_cnt1", grant_cnt1, 32'(g_cnt[1]));
    check("stall_cnt0", stall_cnt0, 32'(s_cnt[0]));
    check("stall_cnt1", stall_cnt1, 32'(s_cnt[1]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
